maxpool_2x2_stream: RTL
=======================

Name: maxpool_2x2_stream

Overview:
- Streaming 2x2 stride-2 max-pooling stage; sits directly downstream of the ReLU stage in the conv datapath.
- Consumes one signed activation per valid cycle in raster order (row-major, one feature map at a time).
- Emits one pooled value per 2x2 window, plus an end-of-map flag, to the next layer's buffer.

Parameters:
- DATA_WIDTH, 20, activation width in bits, signed two's complement; matches the ReLU output width.
- IMG_W, 28, input feature-map width in pixels; must be even and >= 2.
- IMG_H, 28, input feature-map height in pixels; must be even and >= 2.

Ports:
- clk  input  1  clock; all logic is rising-edge.
- rst_n  input  1  asynchronous active-low reset.
- in_valid  input  1  in_data is a valid pixel this cycle.
- in_sof  input  1  qualified by in_valid; this pixel is (row 0, col 0) of a new map.
- in_data  input  DATA_WIDTH  signed activation from the ReLU stage.
- out_valid  output  1  out_data is valid this cycle (single-cycle pulse per window).
- out_data  output  DATA_WIDTH  signed pooled result.
- out_last  output  1  asserted with out_valid on the final window of a map.
- err_sof  output  1  one-cycle pulse when in_sof arrives while col/row are not both 0.

Behaviour:
- Reset: out_valid=0, out_data=0, out_last=0, err_sof=0; col=0, row=0; pair register cleared. Line-buffer contents are don't-care because they are never read before being written.
- Counters: col in 0..IMG_W-1 and row in 0..IMG_H-1 advance only on in_valid. col wraps to 0 and increments row; at (IMG_H-1, IMG_W-1) both wrap to 0.
- No backpressure. in_valid may have arbitrary gaps, and a gap does not disturb any state.
- Even col: latch in_data into the pair register.
- Odd col: hmax = signed max(pair register, in_data).
  - Even row: write hmax into line buffer entry [col>>1]. The line buffer has IMG_W/2 entries of DATA_WIDTH bits.
  - Odd row: result = signed max(line buffer [col>>1], hmax).
- Output timing: out_valid and out_data are registered, so out_valid rises exactly 1 cycle after the bottom-right pixel of a window is accepted. out_last=1 only on the window containing (IMG_H-1, IMG_W-1).
- out_valid, out_last and err_sof deassert on the next cycle. out_data holds its value until the next window.
- Comparisons are signed (DATA_WIDTH-bit). Ties select either operand, since the value is identical. No width growth.
- SOF resync: in_valid && in_sof forces this pixel to be treated as (0,0). After it, col=1 and row=0.
  - If the counters were not already at (0,0), err_sof pulses 1 cycle later and the partial window/row is discarded with no output.
  - An in_sof at (0,0) is silent.
- Reset mid-map: all state returns to reset values immediately. The next accepted pixel is (0,0) regardless of in_sof.
- Output rate: at most one out_valid per two input cycles. A map produces exactly (IMG_W/2)*(IMG_H/2) outputs.
- Elaboration check: odd or zero IMG_W/IMG_H is a fatal elaboration error.

Optional Feature:
- Macro MAXPOOL_AVG_EN.
- Defined:
  - The block performs 2x2 average pooling instead of max pooling.
  - The pair register, line buffer and the internal adder are widened to DATA_WIDTH+2 bits and hold sums instead of maxima.
  - out_data = (sum of 4 pixels) >>> 2, an arithmetic shift that floors toward negative infinity, truncated to DATA_WIDTH bits. The result always fits.
  - Latency, handshake, counters, out_last and err_sof are unchanged.
- Undefined: max pooling as described under Behaviour.

Test Plan:
- 4x4 map (IMG_W=IMG_H=4), pixels 0..15 raster order, in_valid continuous -> outputs 5,7,13,15; out_last only with 15; each out_valid 1 cycle after pixels 5,7,13,15 respectively.
- Same map with in_valid toggling 1-0-1-0 and random 3-cycle gaps -> identical output sequence 5,7,13,15; no spurious out_valid.
- Negative window {-7,-3,-9,-4} (top-left, rest zeros) -> first output -3; all-zero windows -> 0.
- Send pixels 0..5, then in_sof with a fresh 0..15 map -> err_sof pulses once; no output for the aborted window; then outputs 5,7,13,15.
- Assert rst_n=0 after 10 pixels for 2 cycles, then stream 0..15 -> all outputs 0 during reset; afterwards 5,7,13,15 with out_last on 15.
- MAXPOOL_AVG_EN defined, 0..15 map -> 2,4,10,12; window {-1,-2,-3,-4} -> -3.

Source files
------------

// File: rtl/maxpool_2x2_stream.sv
// maxpool_2x2_stream: streaming 2x2 stride-2 max pooling over raster-order activations.
// Define MAXPOOL_AVG_EN to switch to 2x2 average pooling (floored sum >>> 2).
module maxpool_2x2_stream #(
  parameter int DATA_WIDTH = 20,
  parameter int IMG_W = 28,
  parameter int IMG_H = 28
) (
  input  logic                  clk,
  input  logic                  rst_n,
  input  logic                  in_valid,
  input  logic                  in_sof,
  input  logic [DATA_WIDTH-1:0] in_data,
  output logic                  out_valid,
  output logic [DATA_WIDTH-1:0] out_data,
  output logic                  out_last,
  output logic                  err_sof
);
`ifdef MAXPOOL_AVG_EN
  localparam int AW = DATA_WIDTH + 2;
`else
  localparam int AW = DATA_WIDTH;
`endif
  localparam int CW = $clog2(IMG_W);
  localparam int RW = $clog2(IMG_H);
  localparam int LW = IMG_W > 2 ? $clog2(IMG_W / 2) : 1;
  if (IMG_W < 2 || IMG_W % 2 != 0 || IMG_H < 2 || IMG_H % 2 != 0) begin : g_bad_dims
    $fatal(1, "maxpool_2x2_stream: IMG_W and IMG_H must be even and >= 2");
  end
  function automatic logic signed [AW-1:0] pool_op(input logic signed [AW-1:0] a, input logic signed [AW-1:0] b);
`ifdef MAXPOOL_AVG_EN
    return a + b;
`else
    return a > b ? a : b;
`endif
  endfunction
  logic [CW-1:0] col_q, col_d, col_c;
  logic [RW-1:0] row_q, row_d, row_c;
  logic signed [AW-1:0] pair_q, pair_d, din, hv, res;
  logic signed [AW-1:0] lb_q [IMG_W/2];
  logic [LW-1:0] idx;
  logic lb_we, first, last_col, last_row;
  logic out_valid_q, out_valid_d, out_last_q, out_last_d, err_sof_q, err_sof_d;
  logic [DATA_WIDTH-1:0] out_data_q, out_data_d;
  always_comb begin
    first = in_valid && in_sof;
    col_c = first ? '0 : col_q;
    row_c = first ? '0 : row_q;
    last_col = col_c == CW'(IMG_W - 1);
    last_row = row_c == RW'(IMG_H - 1);
    idx = LW'(col_c >> 1);
    din = AW'($signed(in_data));
    hv = pool_op(pair_q, din);
    res = pool_op(lb_q[idx], hv);
    col_d = col_q;
    row_d = row_q;
    pair_d = pair_q;
    lb_we = 1'b0;
    out_valid_d = 1'b0;
    out_last_d = 1'b0;
    out_data_d = out_data_q;
    err_sof_d = first && (col_q != '0 || row_q != '0);
    if (in_valid) begin
      col_d = last_col ? '0 : col_c + 1'b1;
      row_d = last_col ? (last_row ? '0 : row_c + 1'b1) : row_c;
      if (!col_c[0]) pair_d = din;
      else if (!row_c[0]) lb_we = 1'b1;
      else begin
        out_valid_d = 1'b1;
        out_last_d = last_col && last_row;
`ifdef MAXPOOL_AVG_EN
        out_data_d = DATA_WIDTH'(res >>> 2);
`else
        out_data_d = res;
`endif
      end
    end
  end
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      col_q <= '0;
      row_q <= '0;
      pair_q <= '0;
      out_valid_q <= 1'b0;
      out_last_q <= 1'b0;
      out_data_q <= '0;
      err_sof_q <= 1'b0;
    end else begin
      col_q <= col_d;
      row_q <= row_d;
      pair_q <= pair_d;
      out_valid_q <= out_valid_d;
      out_last_q <= out_last_d;
      out_data_q <= out_data_d;
      err_sof_q <= err_sof_d;
    end
  end
  // Line buffer is always written on an even row before the odd row reads it, so it needs no reset.
  always_ff @(posedge clk) begin
    if (lb_we) lb_q[idx] <= hv;
  end
  assign out_valid = out_valid_q;
  assign out_data = out_data_q;
  assign out_last = out_last_q;
  assign err_sof = err_sof_q;
endmodule
